// File: rtl/rx_pkg.sv
// Shared constants and types for the receive path.
package rx_pkg;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned BAUD_DIV          = 5208;
  // Ten bit times without a new sample marks a partial word as stale.
  localparam int unsigned TIMEOUT_DEFAULT   = 10 * BAUD_DIV;
  localparam int unsigned WORD_BITS_DEFAULT = 8;

  typedef enum logic {
    IDLE,
    COLLECT
  } packer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   CLK, RST        clock, synchronous active-high reset
//   push/push_data  write request; accepted when push_ok is high
//   push_ok         room available (or a pop is freeing a slot this cycle)
//   pop             read request; ignored when valid is low
//   pop_data        head word, zero when empty
//   valid           FIFO not empty
//   level           number of stored words
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid    = (level != '0);
  assign do_pop   = pop & valid;
  assign push_ok  = (level != LW'(DEPTH)) | do_pop;
  assign do_push  = push & push_ok;
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs receiver samples (LSB first) into words and buffers them.
//   CLK, RST   clock, synchronous active-high reset
//   DI         sampled bit, asynchronous, stable while enviando is high
//   enviando   sample-present level, asynchronous
//   CLR_OVF    clears OVERFLOW
//   READY      consumer takes DATA this cycle
//   DATA       head word (FWFT), VALID = FIFO not empty, LEVEL = words held
//   OVERFLOW   sticky: a completed word was dropped
//   ABORT      one-cycle pulse: partial word discarded by timeout
module rx_word_packer
  import rx_pkg::*;
#(
  parameter int unsigned WORD_BITS      = WORD_BITS_DEFAULT,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int unsigned LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DI,
  input  logic                 enviando,
  input  logic                 CLR_OVF,
  input  logic                 READY,
  output logic [WORD_BITS-1:0] DATA,
  output logic                 VALID,
  output logic [LW-1:0]        LEVEL,
  output logic                 OVERFLOW,
  output logic                 ABORT
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

  logic di_s1, di_s2;
  logic en_s1, en_s2, en_s3;
  logic sample_evt;

  packer_state_t        state, state_nxt;
  logic [WORD_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [TO_W-1:0]      to_cnt, to_cnt_nxt;
  logic                 word_done, word_done_nxt;
  logic                 expire;

  logic                 push_ok;
  logic                 overflow_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      di_s1 <= 1'b0;
      di_s2 <= 1'b0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
      en_s3 <= 1'b0;
    end else begin
      di_s1 <= DI;
      di_s2 <= di_s1;
      en_s1 <= enviando;
      en_s2 <= en_s1;
      en_s3 <= en_s2;
    end
  end

  assign sample_evt = en_s2 & ~en_s3;
  assign expire     = (state == COLLECT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    logic [WORD_BITS-1:0] base_sh;
    logic [CNT_W-1:0]     base_cnt;
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    to_cnt_nxt    = to_cnt;
    word_done_nxt = 1'b0;
    base_sh       = shreg;
    base_cnt      = bit_cnt;

    if (expire) begin
      base_sh     = '0;
      base_cnt    = '0;
      shreg_nxt   = '0;
      bit_cnt_nxt = '0;
      to_cnt_nxt  = '0;
      state_nxt   = IDLE;
    end

    // A sample coinciding with expiry starts a fresh word from the cleared state.
    if (sample_evt) begin
      shreg_nxt  = {di_s2, base_sh[WORD_BITS-1:1]};
      to_cnt_nxt = '0;
      if (base_cnt == CNT_W'(WORD_BITS - 1)) begin
        bit_cnt_nxt   = '0;
        word_done_nxt = 1'b1;
        state_nxt     = IDLE;
      end else begin
        bit_cnt_nxt = base_cnt + CNT_W'(1);
        state_nxt   = COLLECT;
      end
    end else if (state == COLLECT && !expire) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      word_done <= word_done_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (word_done),
    .push_data (shreg),
    .push_ok   (push_ok),
    .pop       (READY),
    .pop_data  (DATA),
    .valid     (VALID),
    .level     (LEVEL)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q <= 1'b0;
    end else if (word_done && !push_ok) begin
      overflow_q <= 1'b1;
    end else if (CLR_OVF) begin
      overflow_q <= 1'b0;
    end
  end

  assign OVERFLOW = overflow_q;
  assign ABORT    = expire & ~RST;

endmodule

// File: doc/rx_word_packer.md
Name: rx_word_packer

Overview:
- Sits directly downstream of the serial receiver stage. Consumes its sampled-bit output DI and the strobe enviando, which are generated on the divided internal clock.
- Resynchronises both signals into CLK, packs the samples LSB-first into WORD_BITS-wide words, and buffers the words in a small FIFO.
- Presents the words to the command logic through a VALID/READY handshake.
- Discards stale partial words on inactivity timeout and flags lost words.

Parameters:
- WORD_BITS, 8, number of received samples packed per output word (legal range 2..16).
- FIFO_DEPTH, 4, words of buffering; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 52080, CLK cycles without a new sample before a partial word is discarded (10 bit times at divisor 5208).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- DI  in  1  sampled data bit from the receiver; asynchronous to CLK and stable while enviando is high.
- enviando  in  1  sample-present level from the receiver; asynchronous to CLK; high for at least one internal-clock period.
- CLR_OVF  in  1  single-cycle request to clear OVERFLOW.
- READY  in  1  consumer accepts DATA this cycle.
- DATA  out  WORD_BITS  head-of-FIFO word; first-word-fall-through.
- VALID  out  1  FIFO not empty.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  number of words stored.
- OVERFLOW  out  1  sticky: a completed word was dropped.
- ABORT  out  1  one-cycle pulse: a partial word was discarded by timeout.

Behaviour:
- Reset: RST is sampled on the CLK edge only. It clears synchronisers, shift register, bit count, timeout counter and FIFO pointers. Outputs after reset: DATA=0, VALID=0, LEVEL=0, OVERFLOW=0, ABORT=0. Reset mid-word or mid-transfer discards all contents, with no ABORT pulse.
- Synchronisation: DI and enviando each pass through 2 flops. A third flop on enviando gives the rising-edge pulse sample_evt = en_s2 & ~en_s3. The synchronised DI (di_s2) is captured on sample_evt. One sample is taken per enviando high period, whatever its length.
- Latency: a rising edge of enviando that is seen on cycle k produces sample_evt in cycle k+2. The last bit of a word is captured at k+2. The word is written into the FIFO at k+3, and VALID rises at k+3 if the FIFO was empty.
- Packing: on sample_evt the shift register shifts right and di_s2 enters at the MSB, so the first sample ends in bit 0. bit_cnt counts 0..WORD_BITS-1. When the sample that completes a word arrives, word_done pulses for one cycle and bit_cnt wraps to 0.
- FIFO:
  - A push is accepted if LEVEL<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Pop happens when VALID&READY.
  - Simultaneous push and pop leave LEVEL unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop with VALID=0 is ignored.
- Overflow: if a push is refused, the word is dropped and OVERFLOW is set in the next cycle. OVERFLOW holds until CLR_OVF or RST. If CLR_OVF and a new drop occur in the same cycle, the set wins.
- Timeout:
  - to_cnt counts only while bit_cnt!=0, and reloads to 0 on each sample_evt.
  - When to_cnt reaches TIMEOUT_CYCLES-1, bit_cnt and the shift register clear and ABORT pulses for 1 cycle.
  - If sample_evt coincides with expiry, the sample is kept: it becomes bit 0 of a fresh word and ABORT still pulses.
- Width rules: to_cnt has width $clog2(TIMEOUT_CYCLES). LEVEL arithmetic cannot overflow because push is blocked when full.
- FSM (packer): IDLE (bit_cnt==0, timer stopped) -> COLLECT on sample_evt -> IDLE when the word completes or on timeout. In WORD_BITS==1 style degenerate use, every sample completes a word.

Decomposition:
- Shared package rx_pkg holds:
  - CLK_HZ=50_000_000
  - BAUD_DIV=5208
  - bit-time-derived TIMEOUT default
  - WORD_BITS default
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides FWFT storage with LEVEL, push_ok and pop ports. It is reusable by the future transmitter path.
- Synchroniser and edge detection stay inline.

Test Plan:
- Reset then 8 enviando pulses with DI=1,0,1,1,0,0,1,0, each high for 2604 cycles -> DATA=8'h4D, VALID rises 3 cycles after the 8th edge, LEVEL=1, ABORT=0.
- 5 words pushed with READY=0 and FIFO_DEPTH=4 -> LEVEL=4, 5th word dropped, OVERFLOW=1. Then CLR_OVF -> OVERFLOW=0, and DATA pops the first 4 words in order.
- FIFO full with READY=1 held while the 5th word completes -> push and pop in the same cycle, LEVEL stays 4, no OVERFLOW.
- 3 samples then no activity -> ABORT pulses once exactly TIMEOUT_CYCLES after the 3rd sample_evt. The next 8 samples form a clean word with no leftover bits.
- RST asserted for 1 cycle after 5 samples with the FIFO holding 2 words -> VALID=0, LEVEL=0, and the next 8 samples produce exactly one correct word.
- enviando held high for 20000 cycles -> only one sample is counted. DI toggling while enviando is low -> no samples.
